// File: rtl/store_queue_if.sv
// Store queue port bundle: dispatch, AGU/regread updates, commit/flush and the D-cache drain.
// Optional STORE_FORWARD_EN adds the load forwarding lookup signals.
interface store_queue_if #(
  parameter int SQ_SEL   = 3,
  parameter int ROB_SEL  = 6,
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                dispatch_store_valid_1;
  logic                dispatch_store_valid_2;
  logic [ROB_SEL-1:0]  rob_idx_1;
  logic [ROB_SEL-1:0]  rob_idx_2;
  logic [SQ_SEL-1:0]   sq_idx_1;
  logic [SQ_SEL-1:0]   sq_idx_2;
  logic                addr_valid;
  logic [SQ_SEL-1:0]   addr_sq_idx;
  logic [ADDR_LEN-1:0] calculated_address;
  logic                data_valid;
  logic [SQ_SEL-1:0]   data_sq_idx;
  logic [DATA_LEN-1:0] store_data;
  logic                commit_store;
  logic                flush;
  logic                mem_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [ROB_SEL-1:0]  mem_rob_idx;
  logic                mem_ack;
  logic                sq_full;
  logic                sq_empty;
`ifdef STORE_FORWARD_EN
  logic [ADDR_LEN-1:0] fwd_addr;
  logic [ROB_SEL-1:0]  fwd_rob_idx;
  logic                fwd_hit;
  logic [DATA_LEN-1:0] fwd_data;
`endif

  modport master (
    output dispatch_store_valid_1, dispatch_store_valid_2, rob_idx_1, rob_idx_2,
    output addr_valid, addr_sq_idx, calculated_address,
    output data_valid, data_sq_idx, store_data, commit_store, flush, mem_ack,
    input  sq_idx_1, sq_idx_2, mem_req, mem_addr, mem_wdata, mem_rob_idx, sq_full, sq_empty
`ifdef STORE_FORWARD_EN
    , output fwd_addr, fwd_rob_idx
    , input  fwd_hit, fwd_data
`endif
  );

  modport slave (
    input  dispatch_store_valid_1, dispatch_store_valid_2, rob_idx_1, rob_idx_2,
    input  addr_valid, addr_sq_idx, calculated_address,
    input  data_valid, data_sq_idx, store_data, commit_store, flush, mem_ack,
    output sq_idx_1, sq_idx_2, mem_req, mem_addr, mem_wdata, mem_rob_idx, sq_full, sq_empty
`ifdef STORE_FORWARD_EN
    , input  fwd_addr, fwd_rob_idx
    , output fwd_hit, fwd_data
`endif
  );
endinterface

// File: rtl/store_queue.sv
// Circular LSU store queue: 2-wide allocate, addr/data capture, in-order commit, req/ack drain.
// Define STORE_FORWARD_EN to add the combinational store-to-load forwarding lookup.
module store_queue #(
  parameter int SQ_NUM   = 8,
  parameter int SQ_SEL   = 3,
  parameter int ROB_SEL  = 6,
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input logic          clk,
  input logic          reset,
  store_queue_if.slave sq
);
  localparam logic [SQ_SEL:0]   NUM_CNT    = (SQ_SEL+1)'(SQ_NUM);
  localparam logic [SQ_SEL:0]   NUM_M2_CNT = (SQ_SEL+1)'(SQ_NUM-2);
  localparam logic [SQ_SEL:0]   ONE_CNT    = 1;
  localparam logic [SQ_SEL-1:0] ONE_IDX    = 1;

  typedef enum logic {IDLE, REQ} drain_state_e;
  drain_state_e drain_state, drain_state_next;

  logic [SQ_NUM-1:0]   valid, addr_rdy, data_rdy, committed;
  logic [SQ_NUM-1:0]   valid_next, addr_rdy_next, data_rdy_next, committed_next;
  logic [ADDR_LEN-1:0] addr_q [SQ_NUM];
  logic [DATA_LEN-1:0] data_q [SQ_NUM];
  logic [ROB_SEL-1:0]  rob_q  [SQ_NUM];
  logic [SQ_SEL-1:0]   head, tail, head_next, tail_next, commit_idx;
  logic [SQ_SEL:0]     count, commit_cnt, count_next, commit_cnt_next, n_alloc;
  logic                dispatch_ok, alloc_1, alloc_2, commit_ok, free_head, head_ready, load_mem;
  logic                addr_upd, data_upd;

  // Both ways are accepted together or not at all; flush drops any dispatch.
  assign dispatch_ok = !sq.flush &&
                       ((sq.dispatch_store_valid_1 && sq.dispatch_store_valid_2) ?
                        (count <= NUM_M2_CNT) : (count < NUM_CNT));
  assign alloc_1     = sq.dispatch_store_valid_1 && dispatch_ok;
  assign alloc_2     = sq.dispatch_store_valid_2 && dispatch_ok;
  assign n_alloc     = {{SQ_SEL{1'b0}}, alloc_1} + {{SQ_SEL{1'b0}}, alloc_2};
  assign sq.sq_idx_1 = tail;
  assign sq.sq_idx_2 = sq.dispatch_store_valid_1 ? tail + ONE_IDX : tail;
  assign sq.sq_full  = (count == NUM_CNT);
  assign sq.sq_empty = (count == '0);

  assign addr_upd   = sq.addr_valid && valid[sq.addr_sq_idx];
  assign data_upd   = sq.data_valid && valid[sq.data_sq_idx];
  assign commit_ok  = sq.commit_store && (commit_cnt != count);
  assign commit_idx = head + commit_cnt[SQ_SEL-1:0];
  assign head_ready = valid[head] && committed[head] && addr_rdy[head] && data_rdy[head];
  assign free_head  = (drain_state == REQ) && sq.mem_ack;

  always_comb begin
    commit_cnt_next = commit_cnt;
    if (commit_ok) commit_cnt_next = commit_cnt_next + ONE_CNT;
    if (free_head) commit_cnt_next = commit_cnt_next - ONE_CNT;
    head_next  = free_head ? head + ONE_IDX : head;
    count_next = count + n_alloc - (free_head ? ONE_CNT : '0);
    tail_next  = tail + n_alloc[SQ_SEL-1:0];
    // Committed entries survive a flush, including one committed in the flush cycle.
    if (sq.flush) begin
      count_next = commit_cnt_next;
      tail_next  = head_next + commit_cnt_next[SQ_SEL-1:0];
    end
  end

  always_comb begin
    valid_next     = valid;
    addr_rdy_next  = addr_rdy;
    data_rdy_next  = data_rdy;
    committed_next = committed;
    if (addr_upd)  addr_rdy_next[sq.addr_sq_idx] = 1'b1;
    if (data_upd)  data_rdy_next[sq.data_sq_idx] = 1'b1;
    if (commit_ok) committed_next[commit_idx]    = 1'b1;
    if (free_head) begin
      valid_next[head]     = 1'b0;
      addr_rdy_next[head]  = 1'b0;
      data_rdy_next[head]  = 1'b0;
      committed_next[head] = 1'b0;
    end
    if (alloc_1) begin
      valid_next[tail]     = 1'b1;
      addr_rdy_next[tail]  = 1'b0;
      data_rdy_next[tail]  = 1'b0;
      committed_next[tail] = 1'b0;
    end
    if (alloc_2) begin
      valid_next[sq.sq_idx_2]     = 1'b1;
      addr_rdy_next[sq.sq_idx_2]  = 1'b0;
      data_rdy_next[sq.sq_idx_2]  = 1'b0;
      committed_next[sq.sq_idx_2] = 1'b0;
    end
    if (sq.flush) valid_next = valid_next & committed_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= '0;
      addr_rdy   <= '0;
      data_rdy   <= '0;
      committed  <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      commit_cnt <= '0;
    end else begin
      valid      <= valid_next;
      addr_rdy   <= addr_rdy_next;
      data_rdy   <= data_rdy_next;
      committed  <= committed_next;
      head       <= head_next;
      tail       <= tail_next;
      count      <= count_next;
      commit_cnt <= commit_cnt_next;
    end
  end

  // Payload arrays carry no reset; the valid/rdy bits guard every read.
  always_ff @(posedge clk) begin
    if (addr_upd) addr_q[sq.addr_sq_idx] <= sq.calculated_address;
    if (data_upd) data_q[sq.data_sq_idx] <= sq.store_data;
    if (alloc_1)  rob_q[tail]            <= sq.rob_idx_1;
    if (alloc_2)  rob_q[sq.sq_idx_2]     <= sq.rob_idx_2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drain_state <= IDLE;
    else       drain_state <= drain_state_next;
  end

  always_comb begin
    drain_state_next = drain_state;
    load_mem         = 1'b0;
    case (drain_state)
      IDLE: if (head_ready) begin
        drain_state_next = REQ;
        load_mem         = 1'b1;
      end
      REQ:  if (sq.mem_ack) drain_state_next = IDLE;
    endcase
  end

  assign sq.mem_req = (drain_state == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq.mem_addr    <= '0;
      sq.mem_wdata   <= '0;
      sq.mem_rob_idx <= '0;
    end else if (load_mem) begin
      sq.mem_addr    <= addr_q[head];
      sq.mem_wdata   <= data_q[head];
      sq.mem_rob_idx <= rob_q[head];
    end
  end

`ifdef STORE_FORWARD_EN
  logic [SQ_SEL-1:0]  fwd_idx;
  logic [ROB_SEL-1:0] fwd_load_age, fwd_entry_age;
  logic               fwd_older;

  // Walk oldest to youngest; ROB ages are taken relative to the head store to survive wrap.
  always_comb begin
    sq.fwd_hit    = 1'b0;
    sq.fwd_data   = '0;
    fwd_older     = 1'b1;
    fwd_idx       = head;
    fwd_entry_age = '0;
    fwd_load_age  = sq.fwd_rob_idx - rob_q[head];
    for (int i = 0; i < SQ_NUM; i++) begin
      fwd_idx = head + SQ_SEL'(i);
      if ((SQ_SEL+1)'(i) < count && valid[fwd_idx]) begin
        fwd_entry_age = rob_q[fwd_idx] - rob_q[head];
        if (fwd_entry_age >= fwd_load_age) fwd_older = 1'b0;
        if (fwd_older && addr_rdy[fwd_idx] && data_rdy[fwd_idx] &&
            addr_q[fwd_idx] == sq.fwd_addr) begin
          sq.fwd_hit  = 1'b1;
          sq.fwd_data = data_q[fwd_idx];
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_store_queue.sv
// Directed scoreboard bench for store_queue; forwarding steps build only with STORE_FORWARD_EN.
`timescale 1ns/1ps
module tb_store_queue;
  localparam int SQ_NUM = 8, SQ_SEL = 3, ROB_SEL = 6, ADDR_LEN = 32, DATA_LEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_queue_if #(.SQ_SEL(SQ_SEL), .ROB_SEL(ROB_SEL), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) sq ();

  store_queue #(.SQ_NUM(SQ_NUM), .SQ_SEL(SQ_SEL), .ROB_SEL(ROB_SEL),
                .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN))
    dut (.clk(clk), .reset(reset), .sq(sq.slave));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  rob;
  } st_t;

  st_t         sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [2:0]  tb_tail;
  logic [2:0]  h;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sq.dispatch_store_valid_1 = 1'b0;
    sq.dispatch_store_valid_2 = 1'b0;
    sq.rob_idx_1              = '0;
    sq.rob_idx_2              = '0;
    sq.addr_valid             = 1'b0;
    sq.addr_sq_idx            = '0;
    sq.calculated_address     = '0;
    sq.data_valid             = 1'b0;
    sq.data_sq_idx            = '0;
    sq.store_data             = '0;
    sq.commit_store           = 1'b0;
    sq.flush                  = 1'b0;
    sq.mem_ack                = 1'b0;
`ifdef STORE_FORWARD_EN
    sq.fwd_addr               = '0;
    sq.fwd_rob_idx            = '0;
`endif
  endtask

  task automatic dispatch(input logic v1, input logic v2, input logic [5:0] r1, input logic [5:0] r2);
    sq.dispatch_store_valid_1 = v1;
    sq.dispatch_store_valid_2 = v2;
    sq.rob_idx_1              = r1;
    sq.rob_idx_2              = r2;
    tick();
    sq.dispatch_store_valid_1 = 1'b0;
    sq.dispatch_store_valid_2 = 1'b0;
  endtask

  task automatic write_ad(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    sq.addr_valid         = 1'b1;
    sq.addr_sq_idx        = idx;
    sq.calculated_address = a;
    sq.data_valid         = 1'b1;
    sq.data_sq_idx        = idx;
    sq.store_data         = d;
    tick();
    sq.addr_valid = 1'b0;
    sq.data_valid = 1'b0;
  endtask

  task automatic commit();
    sq.commit_store = 1'b1;
    tick();
    sq.commit_store = 1'b0;
  endtask

  // Wait (bounded) for a request, compare against the oldest expected store, then ack it.
  task automatic drain_one(input int exp_wait);
    st_t e;
    int  w;
    w = 0;
    while (!sq.mem_req && w < 20) begin
      tick();
      w++;
    end
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    check("drain_req",   64'(sq.mem_req),     64'd1);
    check("drain_addr",  64'(sq.mem_addr),    64'(e.addr));
    check("drain_wdata", 64'(sq.mem_wdata),   64'(e.data));
    check("drain_rob",   64'(sq.mem_rob_idx), 64'(e.rob));
    if (exp_wait >= 0) check("drain_wait", 64'(w), 64'(exp_wait));
    sq.mem_ack = 1'b1;
    tick();
    sq.mem_ack = 1'b0;
    check("drain_bubble", 64'(sq.mem_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_empty", 64'(sq.sq_empty),  64'd1);
    check("rst_full",  64'(sq.sq_full),   64'd0);
    check("rst_req",   64'(sq.mem_req),   64'd0);
    check("rst_addr",  64'(sq.mem_addr),  64'd0);
    check("rst_wdata", 64'(sq.mem_wdata), 64'd0);

    // Two-way dispatch into an empty queue
    sq.dispatch_store_valid_1 = 1'b1;
    sq.dispatch_store_valid_2 = 1'b1;
    sq.rob_idx_1 = 6'd5;
    sq.rob_idx_2 = 6'd6;
    #1;
    check("idx1_first", 64'(sq.sq_idx_1), 64'd0);
    check("idx2_first", 64'(sq.sq_idx_2), 64'd1);
    tick();
    sq.dispatch_store_valid_1 = 1'b0;
    sq.dispatch_store_valid_2 = 1'b0;
    check("count_2",  64'(dut.count),    64'd2);
    check("tail_2",   64'(sq.sq_idx_1),  64'd2);
    check("nonempty", 64'(sq.sq_empty),  64'd0);

    // Fill to 7, reject a pair, accept a single to full, reject when full
    dispatch(1'b1, 1'b1, 6'd7, 6'd8);
    dispatch(1'b1, 1'b1, 6'd9, 6'd10);
    dispatch(1'b1, 1'b0, 6'd11, 6'd0);
    check("count_7", 64'(dut.count), 64'd7);
    dispatch(1'b1, 1'b1, 6'd20, 6'd21);
    check("pair_rejected_count", 64'(dut.count),   64'd7);
    check("pair_rejected_tail",  64'(sq.sq_idx_1), 64'd7);
    check("not_full_7",          64'(sq.sq_full),  64'd0);
    dispatch(1'b1, 1'b0, 6'd12, 6'd0);
    check("count_8", 64'(dut.count),   64'd8);
    check("full_8",  64'(sq.sq_full),  64'd1);
    dispatch(1'b0, 1'b1, 6'd0, 6'd22);
    check("full_reject_count", 64'(dut.count),   64'd8);
    check("full_tail_wrap",    64'(sq.sq_idx_1), 64'd0);

    // Entry 0: data before address, then commit and a slow ack
    sq.data_valid = 1'b1; sq.data_sq_idx = 3'd0; sq.store_data = 32'hDEAD;
    tick();
    sq.data_valid = 1'b0;
    sq.addr_valid = 1'b1; sq.addr_sq_idx = 3'd0; sq.calculated_address = 32'h100;
    tick();
    sq.addr_valid = 1'b0;
    sb.push_back('{addr: 32'h100, data: 32'hDEAD, rob: 6'd5});
    commit();
    check("req_not_yet", 64'(sq.mem_req), 64'd0);
    tick();
    begin
      st_t e;
      e = sb.pop_front();
      check("req_rise",  64'(sq.mem_req),     64'd1);
      check("req_addr",  64'(sq.mem_addr),    64'(e.addr));
      check("req_wdata", 64'(sq.mem_wdata),   64'(e.data));
      check("req_rob",   64'(sq.mem_rob_idx), 64'(e.rob));
      for (int i = 0; i < 3; i++) begin
        tick();
        check("hold_req",   64'(sq.mem_req),   64'd1);
        check("hold_addr",  64'(sq.mem_addr),  64'(e.addr));
        check("hold_wdata", 64'(sq.mem_wdata), 64'(e.data));
      end
    end
    sq.mem_ack = 1'b1;
    tick();
    sq.mem_ack = 1'b0;
    check("ack_head",  64'(dut.head),   64'd1);
    check("ack_count", 64'(dut.count),  64'd7);
    check("ack_req",   64'(sq.mem_req), 64'd0);
    check("ack_full",  64'(sq.sq_full), 64'd0);

    // Complete and commit entries 1..7, then drain back to back
    for (int i = 1; i < 8; i++)
      write_ad(3'(i), 32'h200 + 32'(i * 4), 32'hA000 + 32'(i));
    for (int i = 1; i < 8; i++) begin
      sb.push_back('{addr: 32'h200 + 32'(i * 4), data: 32'hA000 + 32'(i), rob: 6'(5 + i)});
      commit();
    end
    drain_one(0);
    for (int i = 2; i < 8; i++) drain_one(1);
    check("drained_empty", 64'(sq.sq_empty), 64'd0 + 64'd1);
    tb_tail = 3'd0;

    // Stale updates to a free slot must not make the next store look ready
    write_ad(tb_tail, 32'hBAD0, 32'hBAD1);
    dispatch(1'b1, 1'b0, 6'd30, 6'd0);
    commit();
    repeat (4) tick();
    check("no_req_unready", 64'(sq.mem_req), 64'd0);
    sb.push_back('{addr: 32'h300, data: 32'h3000, rob: 6'd30});
    write_ad(tb_tail, 32'h300, 32'h3000);
    drain_one(-1);
    tb_tail = tb_tail + 3'd1;

    // Wrap: single stores cycling head and tail through 7 -> 0
    for (int k = 0; k < 10; k++) begin
      sq.dispatch_store_valid_1 = 1'b1;
      sq.rob_idx_1 = 6'(32 + k);
      #1;
      check("wrap_idx", 64'(sq.sq_idx_1), 64'(tb_tail));
      tick();
      sq.dispatch_store_valid_1 = 1'b0;
      sb.push_back('{addr: 32'h400 + 32'(k * 4), data: 32'h4000 + 32'(k), rob: 6'(32 + k)});
      write_ad(tb_tail, 32'h400 + 32'(k * 4), 32'h4000 + 32'(k));
      commit();
      drain_one(-1);
      tb_tail = tb_tail + 3'd1;
    end
    check("wrap_empty", 64'(sq.sq_empty), 64'd1);

    // Flush: one committed of four, same-cycle dispatch is dropped
    h = tb_tail;
    dispatch(1'b1, 1'b1, 6'd40, 6'd41);
    dispatch(1'b1, 1'b1, 6'd42, 6'd43);
    commit();
    sq.flush = 1'b1;
    dispatch(1'b1, 1'b1, 6'd50, 6'd51);
    sq.flush = 1'b0;
    check("flush_count", 64'(dut.count),   64'd1);
    check("flush_tail",  64'(sq.sq_idx_1), 64'(h + 3'd1));
    commit();
    sq.dispatch_store_valid_2 = 1'b1;
    sq.rob_idx_2 = 6'd44;
    #1;
    check("way2_only_idx", 64'(sq.sq_idx_2), 64'(h + 3'd1));
    tick();
    sq.dispatch_store_valid_2 = 1'b0;
    check("way2_count", 64'(dut.count), 64'd2);
    sq.flush = 1'b1;
    tick();
    sq.flush = 1'b0;
    check("commit_ignored_flush", 64'(dut.count), 64'd1);
    dispatch(1'b1, 1'b0, 6'd45, 6'd0);
    sq.flush = 1'b1;
    commit();
    sq.flush = 1'b0;
    check("flush_commit_count", 64'(dut.count),   64'd2);
    check("flush_commit_tail",  64'(sq.sq_idx_1), 64'(h + 3'd2));
    sb.push_back('{addr: 32'h500, data: 32'h5000, rob: 6'd40});
    sb.push_back('{addr: 32'h504, data: 32'h5004, rob: 6'd45});
    write_ad(h, 32'h500, 32'h5000);
    write_ad(h + 3'd1, 32'h504, 32'h5004);
    drain_one(-1);
    drain_one(-1);
    check("flush_drained", 64'(sq.sq_empty), 64'd1);
    tb_tail = h + 3'd2;

`ifdef STORE_FORWARD_EN
    // Forwarding: two stores to the same address, youngest older one wins
    dispatch(1'b1, 1'b1, 6'd60, 6'd61);
    write_ad(tb_tail, 32'h40, 32'd1);
    write_ad(tb_tail + 3'd1, 32'h40, 32'd2);
    sq.fwd_addr = 32'h40;
    sq.fwd_rob_idx = 6'd62;
    #1;
    check("fwd_hit_young",  64'(sq.fwd_hit),  64'd1);
    check("fwd_data_young", 64'(sq.fwd_data), 64'd2);
    sq.fwd_rob_idx = 6'd61;
    #1;
    check("fwd_hit_mid",  64'(sq.fwd_hit),  64'd1);
    check("fwd_data_mid", 64'(sq.fwd_data), 64'd1);
    sq.fwd_addr = 32'h44;
    #1;
    check("fwd_miss_hit",  64'(sq.fwd_hit),  64'd0);
    check("fwd_miss_data", 64'(sq.fwd_data), 64'd0);
    sq.flush = 1'b1;
    tick();
    sq.flush = 1'b0;
    check("fwd_flush_empty", 64'(sq.sq_empty), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
